alu_execute_stage: RTL and testbench

Execute stage of the Mini-MIPS datapath, directly downstream of the instruction fetch/decode stage. Consumes decoded fields and register operands, computes single-cycle ALU results, and runs iterative 32-cycle multiply/divide into HI/LO. Produces a registered writeback request (destination register, data, enable) for the register-file write port.

---
 rtl/alu_execute_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_execute_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
// Mini-MIPS execute stage: single-cycle ALU ops with a registered writeback
// request, plus a 32-iteration shift-add multiply / restoring divide into HI/LO.
module alu_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  R_type,
    input  logic [1:0]  I_type,
    input  logic [5:0]  ins_op_code,
    input  logic [5:0]  ins_func,
    input  logic [4:0]  ins_rt,
    input  logic [4:0]  ins_rd,
    input  logic [4:0]  ins_shamt,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [15:0] imm,
    output logic        out_valid,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [31:0] result,
    output logic        overflow,
    output logic        illegal,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [63:0] work_r;
    logic [31:0] opb_r, hi_r, lo_r, result_r;
    logic        neg_q_r, neg_r_r, is_div_r;
    logic        out_valid_r, wr_en_r, overflow_r, illegal_r, busy_r;
    logic [4:0]  wr_reg_r;

    logic [31:0] imm_sx_s, imm_zx_s, add_s, sub_s, addi_s, res_s, rs_mag_s, rt_mag_s;
    logic        add_ovf_s, sub_ovf_s, addi_ovf_s, ovf_s, ill_s, wen_s;
    logic        is_mul_s, is_div_s, sgn_s, accept_s, unused_s;
    logic [4:0]  dst_s;
    logic [32:0] mul_sum_s, div_sh_s, div_diff_s;
    logic [63:0] mul_next_s, div_next_s, prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    assign unused_s   = R_type[1] ^ I_type[1];
    assign in_ready   = (state_r == IDLE);
    assign accept_s   = in_valid && in_ready;
    assign imm_sx_s   = {{16{imm[15]}}, imm};
    assign imm_zx_s   = {16'd0, imm};
    assign add_s      = rs + rt;
    assign sub_s      = rs - rt;
    assign addi_s     = rs + imm_sx_s;
    assign add_ovf_s  = (rs[31] == rt[31]) && (add_s[31] != rs[31]);
    assign sub_ovf_s  = (rs[31] != rt[31]) && (sub_s[31] != rs[31]);
    assign addi_ovf_s = (rs[31] == imm[15]) && (addi_s[31] != rs[31]);

    // Decode and single-cycle ALU result
    always_comb begin
        res_s    = 32'd0;
        ovf_s    = 1'b0;
        ill_s    = 1'b0;
        dst_s    = 5'd0;
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        sgn_s    = 1'b0;
        if (R_type[0] && (ins_op_code == 6'h00)) begin
            dst_s = ins_rd;
            case (ins_func)
                6'h00: res_s = rt << ins_shamt;
                6'h02: res_s = rt >> ins_shamt;
                6'h03: res_s = $signed(rt) >>> ins_shamt;
                6'h20: begin res_s = add_s; ovf_s = add_ovf_s; end
                6'h21: res_s = add_s;
                6'h22: begin res_s = sub_s; ovf_s = sub_ovf_s; end
                6'h23: res_s = sub_s;
                6'h24: res_s = rs & rt;
                6'h25: res_s = rs | rt;
                6'h26: res_s = rs ^ rt;
                6'h27: res_s = ~(rs | rt);
                6'h2A: res_s = {31'd0, ($signed(rs) < $signed(rt))};
                6'h2B: res_s = {31'd0, (rs < rt)};
                6'h10: res_s = hi_r;
                6'h12: res_s = lo_r;
                6'h18: begin is_mul_s = 1'b1; sgn_s = 1'b1; end
                6'h19: is_mul_s = 1'b1;
                6'h1A: begin is_div_s = 1'b1; sgn_s = 1'b1; end
                6'h1B: is_div_s = 1'b1;
                default: ill_s = 1'b1;
            endcase
        end else if (I_type[0]) begin
            dst_s = ins_rt;
            case (ins_op_code)
                6'h08: begin res_s = addi_s; ovf_s = addi_ovf_s; end
                6'h09: res_s = addi_s;
                6'h0A: res_s = {31'd0, ($signed(rs) < $signed(imm_sx_s))};
                6'h0B: res_s = {31'd0, (rs < imm_sx_s)};
                6'h0C: res_s = rs & imm_zx_s;
                6'h0D: res_s = rs | imm_zx_s;
                6'h0E: res_s = rs ^ imm_zx_s;
                6'h0F: res_s = {imm, 16'd0};
                default: ill_s = 1'b1;
            endcase
        end else begin
            ill_s = 1'b1;
        end
    end

    assign wen_s    = !ill_s && !ovf_s && !is_mul_s && !is_div_s && (dst_s != 5'd0);
    assign rs_mag_s = (sgn_s && rs[31]) ? (32'd0 - rs) : rs;
    assign rt_mag_s = (sgn_s && rt[31]) ? (32'd0 - rt) : rt;

    // One shift-add step: upper half accumulates, the multiplier shifts out of the low half
    assign mul_sum_s  = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opb_r} : 33'd0);
    assign mul_next_s = {mul_sum_s, work_r[31:1]};
    // One restoring step: remainder in the upper half, dividend/quotient in the lower half
    assign div_sh_s   = work_r[63:31];
    assign div_diff_s = div_sh_s - {1'b0, opb_r};
    assign div_next_s = div_diff_s[32] ? {div_sh_s[31:0], work_r[30:0], 1'b0}
                                       : {div_diff_s[31:0], work_r[30:0], 1'b1};

    assign prod_fix_s = neg_q_r ? (64'd0 - work_r) : work_r;
    assign quo_fix_s  = neg_q_r ? (32'd0 - work_r[31:0]) : work_r[31:0];
    assign rem_fix_s  = neg_r_r ? (32'd0 - work_r[63:32]) : work_r[63:32];

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_s = MUL;
                end else if (accept_s && is_div_s) begin
                    state_s = (rt == 32'd0) ? FIN : DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL:     state_s = (cnt_r == 5'd31) ? FIN : MUL;
            DIV:     state_s = (cnt_r == 5'd31) ? FIN : DIV;
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, iteration datapath, HI/LO and registered writeback request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            work_r      <= 64'd0;
            opb_r       <= 32'd0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            is_div_r    <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            out_valid_r <= 1'b0;
            wr_en_r     <= 1'b0;
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
            busy_r      <= 1'b0;
            wr_reg_r    <= 5'd0;
            result_r    <= 32'd0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= 1'b0;
            wr_en_r     <= 1'b0;
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && is_mul_s) begin
                        busy_r   <= 1'b1;
                        cnt_r    <= 5'd0;
                        work_r   <= {32'd0, rt_mag_s};
                        opb_r    <= rs_mag_s;
                        neg_q_r  <= sgn_s && (rs[31] ^ rt[31]);
                        neg_r_r  <= 1'b0;
                        is_div_r <= 1'b0;
                    end else if (accept_s && is_div_s) begin
                        busy_r   <= 1'b1;
                        cnt_r    <= 5'd0;
                        is_div_r <= 1'b1;
                        opb_r    <= rt_mag_s;
                        // Divide by zero skips iterating; FIN passes this through unchanged
                        if (rt == 32'd0) begin
                            work_r  <= {rs, 32'hFFFF_FFFF};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                        end else begin
                            work_r  <= {32'd0, rs_mag_s};
                            neg_q_r <= sgn_s && (rs[31] ^ rt[31]);
                            neg_r_r <= sgn_s && rs[31];
                        end
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= ill_s ? 32'd0 : res_s;
                        wr_reg_r    <= dst_s;
                        wr_en_r     <= wen_s;
                        overflow_r  <= ovf_s;
                        illegal_r   <= ill_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MUL: begin
                    work_r <= mul_next_s;
                    cnt_r  <= cnt_r + 5'd1;
                end
                DIV: begin
                    work_r <= div_next_s;
                    cnt_r  <= cnt_r + 5'd1;
                end
                FIN: begin
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    cnt_r       <= 5'd0;
                    result_r    <= 32'd0;
                    wr_reg_r    <= 5'd0;
                    hi_r        <= is_div_r ? rem_fix_s : prod_fix_s[63:32];
                    lo_r        <= is_div_r ? quo_fix_s : prod_fix_s[31:0];
                end
                default: cnt_r <= 5'd0;
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign wr_en     = wr_en_r;
    assign wr_reg    = wr_reg_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign illegal   = illegal_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized ops against an arithmetic reference model.
module tb_alu_execute_stage;
    typedef struct {
        logic        rfmt, ifmt;
        logic [5:0]  op, fn;
        logic [4:0]  rtn, rdn, sh;
        logic [31:0] a, b;
        logic [15:0] im;
        logic [31:0] res;
        logic        wen, ovf, ill;
        logic [4:0]  wreg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [1:0]  R_type, I_type;
    logic [5:0]  ins_op_code, ins_func;
    logic [4:0]  ins_rt, ins_rd, ins_shamt;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic        out_valid, wr_en, overflow, illegal, busy;
    logic [4:0]  wr_reg;
    logic [31:0] result, hi, lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [5:0]  rfuncs [15] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h20, 6'h21, 6'h22,
                                 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [31:0] specials [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vec_t        tbl [15];

    always #5 clk = ~clk;

    alu_execute_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .R_type(R_type), .I_type(I_type), .ins_op_code(ins_op_code), .ins_func(ins_func),
        .ins_rt(ins_rt), .ins_rd(ins_rd), .ins_shamt(ins_shamt), .rs(rs), .rt(rt), .imm(imm),
        .out_valid(out_valid), .wr_en(wr_en), .wr_reg(wr_reg), .result(result),
        .overflow(overflow), .illegal(illegal), .hi(hi), .lo(lo), .busy(busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic r, input logic i, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rtn, input logic [4:0] rdn, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        vec_t v;
        v.rfmt = r; v.ifmt = i; v.op = op; v.fn = fn; v.rtn = rtn; v.rdn = rdn; v.sh = sh;
        v.a = a; v.b = b; v.im = im; v.res = 32'd0; v.wen = 1'b0; v.ovf = 1'b0; v.ill = 1'b0;
        v.wreg = 5'd0;
        return v;
    endfunction

    // Reference: instruction semantics in 64-bit integer arithmetic
    function automatic void ref_alu(input vec_t v, input logic [31:0] h, input logic [31:0] l,
                                    output logic [31:0] res, output logic wen, output logic ovf,
                                    output logic ill, output logic [4:0] dst);
        longint sa, sb, si, s;
        logic   md;
        sa = $signed(v.a); sb = $signed(v.b); si = $signed(v.im);
        res = 32'd0; ovf = 1'b0; ill = 1'b0; md = 1'b0; dst = 5'd0;
        if (v.rfmt && v.op == 6'h00) begin
            dst = v.rdn;
            case (v.fn)
                6'h00: res = v.b << v.sh;
                6'h02: res = v.b >> v.sh;
                6'h03: begin s = sb >>> v.sh; res = s[31:0]; end
                6'h20: begin s = sa + sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); res = s[31:0]; end
                6'h21: res = v.a + v.b;
                6'h22: begin s = sa - sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); res = s[31:0]; end
                6'h23: res = v.a - v.b;
                6'h24: res = v.a & v.b;
                6'h25: res = v.a | v.b;
                6'h26: res = v.a ^ v.b;
                6'h27: res = ~(v.a | v.b);
                6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: res = (v.a < v.b) ? 32'd1 : 32'd0;
                6'h10: res = h;
                6'h12: res = l;
                6'h18, 6'h19, 6'h1A, 6'h1B: md = 1'b1;
                default: ill = 1'b1;
            endcase
        end else if (v.ifmt) begin
            dst = v.rtn;
            case (v.op)
                6'h08: begin s = sa + si; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); res = s[31:0]; end
                6'h09: begin s = sa + si; res = s[31:0]; end
                6'h0A: res = (sa < si) ? 32'd1 : 32'd0;
                6'h0B: begin s = si; res = (v.a < s[31:0]) ? 32'd1 : 32'd0; end
                6'h0C: res = v.a & {16'd0, v.im};
                6'h0D: res = v.a | {16'd0, v.im};
                6'h0E: res = v.a ^ {16'd0, v.im};
                6'h0F: res = {v.im, 16'd0};
                default: ill = 1'b1;
            endcase
        end else begin
            ill = 1'b1;
        end
        if (ill) res = 32'd0;
        wen = !ill && !ovf && !md && (dst != 5'd0);
    endfunction

    function automatic void ref_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a); sb = $signed(b); lat = 33; h = 32'd0; l = 32'd0;
        if (fn == 6'h18) begin
            p = sa * sb; h = p[63:32]; l = p[31:0];
        end else if (fn == 6'h19) begin
            p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0];
        end else if (b == 32'd0) begin
            h = a; l = 32'hFFFF_FFFF; lat = 1;
        end else if (fn == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            h = 32'd0; l = 32'h8000_0000;
        end else if (fn == 6'h1A) begin
            q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
        end else begin
            h = a % b; l = a / b;
        end
    endfunction

    task automatic accept(input vec_t v);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_at_issue", in_ready, 1);
        R_type = {1'b0, v.rfmt}; I_type = {1'b0, v.ifmt}; ins_op_code = v.op; ins_func = v.fn;
        ins_rt = v.rtn; ins_rd = v.rdn; ins_shamt = v.sh; rs = v.a; rt = v.b; imm = v.im;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_single(input string tag, input logic [31:0] res, input logic wen,
                                input logic ovf, input logic ill, input logic [4:0] wreg);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_ovf"}, overflow, ovf);
        check({tag, "_ill"}, illegal, ill);
        check({tag, "_wen"}, wr_en, wen);
        if (!ovf) check({tag, "_result"}, result, res);
        if (!ill) check({tag, "_wreg"}, wr_reg, wreg);
    endtask

    task automatic run_md(input string tag, input vec_t v, input logic [31:0] eh,
                          input logic [31:0] el, input int elat);
        int k;
        accept(v);
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_low"}, in_ready, 0);
        check({tag, "_no_early_valid"}, out_valid, 0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, k, elat);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_wen"}, wr_en, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_ready_back"}, in_ready, 1);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] eres, eh, el;
        logic        ewen, eovf, eill;
        logic [4:0]  edst;
        int          elat, pulses;

        tbl[0]  = '{1'b1, 1'b0, 6'h00, 6'h20, 5'd0,  5'd3,  5'd0,  32'h7FFF_FFFF, 32'h1, 16'h0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd3};
        tbl[1]  = '{1'b1, 1'b0, 6'h00, 6'h21, 5'd0,  5'd3,  5'd0,  32'h7FFF_FFFF, 32'h1, 16'h0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd3};
        tbl[2]  = '{1'b0, 1'b1, 6'h0D, 6'h00, 5'd5,  5'd0,  5'd0,  32'h0000_00F0, 32'h0, 16'h000F, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 5'd5};
        tbl[3]  = '{1'b1, 1'b0, 6'h00, 6'h03, 5'd0,  5'd2,  5'd4,  32'h0, 32'h8000_0000, 16'h0000, 32'hF800_0000, 1'b1, 1'b0, 1'b0, 5'd2};
        tbl[4]  = '{1'b0, 1'b1, 6'h3F, 6'h00, 5'd6,  5'd0,  5'd0,  32'h1234_5678, 32'h0, 16'h1111, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6};
        tbl[5]  = '{1'b0, 1'b1, 6'h09, 6'h00, 5'd0,  5'd0,  5'd0,  32'h5, 32'h0, 16'h0001, 32'h6, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[6]  = '{1'b1, 1'b0, 6'h00, 6'h22, 5'd0,  5'd7,  5'd0,  32'h8000_0000, 32'h1, 16'h0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd7};
        tbl[7]  = '{1'b0, 1'b1, 6'h0A, 6'h00, 5'd9,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0, 16'h0000, 32'h1, 1'b1, 1'b0, 1'b0, 5'd9};
        tbl[8]  = '{1'b0, 1'b1, 6'h0B, 6'h00, 5'd9,  5'd0,  5'd0,  32'h5, 32'h0, 16'hFFFF, 32'h1, 1'b1, 1'b0, 1'b0, 5'd9};
        tbl[9]  = '{1'b0, 1'b1, 6'h0F, 6'h00, 5'd10, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0, 16'h1234, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 5'd10};
        tbl[10] = '{1'b1, 1'b0, 6'h00, 6'h27, 5'd0,  5'd11, 5'd0,  32'h0, 32'hF, 16'h0000, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 5'd11};
        tbl[11] = '{1'b0, 1'b1, 6'h08, 6'h00, 5'd12, 5'd0,  5'd0,  32'h7FFF_FFFF, 32'h0, 16'h0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd12};
        tbl[12] = '{1'b0, 1'b1, 6'h0C, 6'h00, 5'd13, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0, 16'h8001, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 5'd13};
        tbl[13] = '{1'b1, 1'b0, 6'h00, 6'h3F, 5'd0,  5'd14, 5'd0,  32'h1, 32'h2, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd14};
        tbl[14] = '{1'b1, 1'b0, 6'h00, 6'h02, 5'd0,  5'd1,  5'd31, 32'h0, 32'h8000_0000, 16'h0000, 32'h1, 1'b1, 1'b0, 1'b0, 5'd1};

        reset = 1'b1; in_valid = 1'b0; R_type = 2'd0; I_type = 2'd0; ins_op_code = 6'd0;
        ins_func = 6'd0; ins_rt = 5'd0; ins_rd = 5'd0; ins_shamt = 5'd0; rs = 32'd0; rt = 32'd0;
        imm = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_result", result, 0);
        check("rst_wr_reg", wr_reg, 0);
        check("rst_flags", {wr_en, overflow, illegal}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed table, issued back-to-back
        for (int k = 0; k < 15; k++) begin
            accept(tbl[k]);
            check_single($sformatf("tbl%0d", k), tbl[k].res, tbl[k].wen, tbl[k].ovf, tbl[k].ill, tbl[k].wreg);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("valid_pulse_drop", out_valid, 0);

        // Multi-cycle corner cases
        run_md("mult_m3x7", mkv(1'b1, 1'b0, 6'h00, 6'h18, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFD, 32'd7, 16'd0),
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        accept(mkv(1'b1, 1'b0, 6'h00, 6'h12, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 16'd0));
        in_valid = 1'b0;
        check_single("mflo", 32'hFFFF_FFEB, 1'b1, 1'b0, 1'b0, 5'd4);
        accept(mkv(1'b1, 1'b0, 6'h00, 6'h10, 5'd0, 5'd8, 5'd0, 32'd0, 32'd0, 16'd0));
        in_valid = 1'b0;
        check_single("mfhi", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd8);
        run_md("div_m7d2", mkv(1'b1, 1'b0, 6'h00, 6'h1A, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF9, 32'd2, 16'd0),
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_md("divu_by0", mkv(1'b1, 1'b0, 6'h00, 6'h1B, 5'd0, 5'd0, 5'd0, 32'd7, 32'd0, 16'd0),
               32'd7, 32'hFFFF_FFFF, 1);
        run_md("div_minint", mkv(1'b1, 1'b0, 6'h00, 6'h1A, 5'd0, 5'd0, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 16'd0),
               32'd0, 32'h8000_0000, 33);
        run_md("multu_big", mkv(1'b1, 1'b0, 6'h00, 6'h19, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0),
               32'hFFFF_FFFE, 32'h0000_0001, 33);

        // Reset during an iterative multiply
        accept(mkv(1'b1, 1'b0, 6'h00, 6'h18, 5'd0, 5'd0, 5'd0, 32'd1234, 32'd5678, 16'd0));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", in_ready, 1);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("midrst_no_retire", pulses, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Randomized single-cycle ops against the reference model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 0)
                v = mkv(1'b1, 1'b0, 6'h00, rfuncs[$urandom_range(0, 14)], 5'($urandom), 5'($urandom),
                        5'($urandom), 32'($urandom), 32'($urandom), 16'($urandom));
            else
                v = mkv(1'b0, 1'b1, ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(8, 15)),
                        6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 32'($urandom),
                        32'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) v.a = specials[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) v.b = specials[$urandom_range(0, 3)];
            if (v.rfmt && (v.fn == 6'h18 || v.fn == 6'h19 || v.fn == 6'h1A || v.fn == 6'h1B)) v.fn = 6'h21;
            ref_alu(v, m_hi, m_lo, eres, ewen, eovf, eill, edst);
            accept(v);
            check_single($sformatf("rnd%0d", k), eres, ewen, eovf, eill, edst);
        end
        in_valid = 1'b0;

        // Randomized multiply/divide, HI/LO tracked for later mfhi/mflo
        for (int k = 0; k < 24; k++) begin
            v = mkv(1'b1, 1'b0, 6'h00, 6'h18 + 6'($urandom_range(0, 3)), 5'd0, 5'($urandom), 5'd0,
                    32'($urandom), 32'($urandom), 16'd0);
            if ($urandom_range(0, 3) == 0) v.a = specials[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) v.b = 32'd0;
            else if ($urandom_range(0, 3) == 0) v.b = 32'($urandom_range(1, 9));
            ref_md(v.fn, v.a, v.b, eh, el, elat);
            run_md($sformatf("rmd%0d", k), v, eh, el, elat);
            v = mkv(1'b1, 1'b0, 6'h00, ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12, 5'd0, 5'd17, 5'd0,
                    32'd0, 32'd0, 16'd0);
            ref_alu(v, m_hi, m_lo, eres, ewen, eovf, eill, edst);
            accept(v);
            in_valid = 1'b0;
            check_single($sformatf("rmf%0d", k), eres, ewen, eovf, eill, edst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
